// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_unit: execute unit; 1-cycle logic/arith/compare, 1-bit/cycle     |
// | shifts, valid/ready handshake on both sides.          Revision: 1.0       |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_right_q, dir_right_d;
  logic               fill_q, fill_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shreg_next;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  // Shifts by zero bypass the iterative path and return op_a unchanged.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  assign shreg_next = dir_right_q ? {fill_q, shreg_q[WIDTH-1:1]}
                                  : {shreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      fill_q      <= fill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    fill_d      = fill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            shreg_d     = op_a;
            cnt_d       = shamt;
            dir_right_d = (alu_ctrl != OP_SLL);
            fill_d      = (alu_ctrl == OP_SRA) && op_a[WIDTH-1];
            state_d     = S_SHIFT;
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_next;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shreg_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
    zero      = (result_q == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_exec_unit: directed vector table plus backpressure/reset cases.    |
// |                                                       Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready high, measure latency, then confirm the handshake.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_z, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0003;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, 32'(zero), 32'(exp_z));
    check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, " out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};  // ADD wrap
    vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1};  // SUB
    vecs[2]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};  // SLT -1<1
    vecs[3]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};  // SLTU
    vecs[4]  = '{4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5};  // SRA 4
    vecs[5]  = '{4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 5};  // SRL 4
    vecs[6]  = '{4'b0100, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1};  // SLL 0
    vecs[7]  = '{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32}; // SLL 31
    vecs[8]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};  // AND
    vecs[9]  = '{4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1};  // OR
    vecs[10] = '{4'b0011, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1};  // XOR
    vecs[11] = '{4'b0100, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 1'b0, 4};  // SLL 3, upper b ignored
    vecs[12] = '{4'b1111, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1};  // undefined
    vecs[13] = '{4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};  // SLT 1<-1
    vecs[14] = '{4'b1001, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 5};  // SRA positive
    vecs[15] = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1};  // SUB wrap
    vecs[16] = '{4'b1010, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};  // undefined

    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].z, vecs[i].lat);
    end

    // Backpressure: ADD 3+4 held for 6 cycles while inputs are wiggled.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0010;
    op_a      = 32'd3;
    op_b      = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("bp latency", 32'(lat), 32'd1);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      op_a     = 32'h100 + 32'(k);
      @(negedge clk);
      check($sformatf("bp out_valid c%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp result c%0d", k), result, 32'd7);
      check($sformatf("bp in_ready c%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp in_ready after hs", 32'(in_ready), 32'd1);
    check("bp out_valid after hs", 32'(out_valid), 32'd0);
    run_op("bp next", 4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1);

    // Reset two cycles into a 10-bit SLL, with in_valid asserted alongside reset.
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b0100;
    op_a     = 32'h1;
    op_b     = 32'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst mid-shift out_valid", 32'(out_valid), 32'd0);
    reset    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'b0010;
    op_a     = 32'd1;
    op_b     = 32'd1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rst quiet out_valid c%0d", k), 32'(out_valid), 32'd0);
    end
    run_op("rst xor", 4'b0011, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1);
    run_op("rst undef", 4'b1111, 32'hAAAA_5555, 32'h1234_5678, 32'h0000_0000, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
